// File: rtl/openfire_decode_prefetch_pkg.sv
// Shared decode constants for the OpenFire prefetch/fuse stage and DECODE:
// opcodes, delay-slot bit positions, the brali template and small helpers.
package openfire_decode_prefetch_pkg;

    localparam logic [5:0] OP_IMM  = 6'b101100;
    localparam logic [5:0] OP_BR   = 6'b100110;
    localparam logic [5:0] OP_BCC  = 6'b100111;
    localparam logic [5:0] OP_RTS  = 6'b101101;
    // Immediate forms of BR/BCC share the register forms' delay-bit position
    localparam logic [5:0] OP_BRI  = 6'b101110;
    localparam logic [5:0] OP_BCCI = 6'b101111;

    localparam int unsigned BR_DELAY_BIT  = 20;
    localparam int unsigned BCC_DELAY_BIT = 25;

    // ra field of brali: D=0, A=1, L=1 (absolute branch-and-link, no delay slot)
    localparam logic [4:0] BRALI_FLAGS = 5'b01100;

    // Source of the word presented to DECODE
    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_SINGLE,
        SRC_FUSED,
        SRC_INJECT
    } out_src_e;

    function automatic logic is_imm(input logic [31:0] instr);
        return instr[31:26] == OP_IMM;
    endfunction

    function automatic logic delay_bit(input logic [31:0] instr);
        logic d;
        d = 1'b0;
        case (instr[31:26])
            OP_BR, OP_BRI:   d = instr[BR_DELAY_BIT];
            OP_BCC, OP_BCCI: d = instr[BCC_DELAY_BIT];
            OP_RTS:          d = 1'b1;
            default:         d = 1'b0;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] brali(input logic [4:0] rd, input logic [15:0] vec);
        return {OP_BRI, rd, BRALI_FLAGS, vec};
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/openfire_decode_prefetch_ibuf_fifo.sv
// openfire_ibuf_fifo: DEPTH-entry show-ahead instruction queue.
// Registered write, combinational peek of head and head+1, pop-1/pop-2,
// synchronous clear. Owns the occupancy count.
module openfire_ibuf_fifo #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned W     = 64,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic          i_clock,
    input  logic          i_reset_n,
    input  logic          i_clear,
    input  logic          i_push,
    input  logic [W-1:0]  i_push_data,
    input  logic          i_pop1,
    input  logic          i_pop2,
    output logic [W-1:0]  o_head,
    output logic [W-1:0]  o_head_nxt,
    output logic [CW-1:0] o_count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic [AW-1:0] w_rd_step;
    logic [CW-1:0] w_cnt_dec;

    always_comb begin
        w_rd_step = '0;
        w_cnt_dec = '0;
        if (i_pop2) begin
            w_rd_step = AW'(2);
            w_cnt_dec = CW'(2);
        end else if (i_pop1) begin
            w_rd_step = AW'(1);
            w_cnt_dec = CW'(1);
        end
    end

    // Storage write; data words need no reset
    always_ff @(posedge i_clock) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers and count; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge i_clock) begin
        if (!i_reset_n || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= r_rd_ptr + w_rd_step;
            r_count  <= r_count + CW'(i_push) - w_cnt_dec;
        end
    end

    assign o_head     = r_mem[r_rd_ptr];
    assign o_head_nxt = r_mem[r_rd_ptr + AW'(1)];
    assign o_count    = r_count;

endmodule

// File: rtl/openfire_decode_prefetch.sv
// openfire_decode_prefetch: prefetch queue between FETCH and DECODE.
// Fuses an IMM prefix with its follower into one 32-bit-immediate word.
// Optional interrupt-branch injection is built when OPENFIRE_INT_INJECT_EN
// is defined (adds int_req/int_ack ports and delay-slot tracking).
module openfire_decode_prefetch
    import openfire_decode_prefetch_pkg::*;
#(
    parameter int unsigned PC_W        = 32,
    parameter int unsigned DEPTH       = 4,
    parameter logic [31:0] INT_VECTOR  = 32'h10,
    parameter int unsigned INT_RET_REG = 14
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [PC_W-1:0] out_pc,
    output logic [31:0]     out_imm,
    output logic            out_fused
`ifdef OPENFIRE_INT_INJECT_EN
    ,
    input  logic            int_req,
    output logic            int_ack
`endif
);

    localparam int unsigned W  = 32 + PC_W;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [4:0]  RET_RD = 5'(INT_RET_REG);

    logic [W-1:0]    w_head;
    logic [W-1:0]    w_head_nxt;
    logic [CW-1:0]   w_count;
    logic [31:0]     w_head_instr;
    logic [PC_W-1:0] w_head_pc;
    logic [31:0]     w_nxt_instr;
    logic            w_have1;
    logic            w_have2;
    logic            w_head_imm;
    logic            w_norm_valid;
    logic            w_inject;
    logic            w_push;
    logic            w_fire;
    logic            w_pop1;
    logic            w_pop2;
    out_src_e        w_src;

    assign w_head_instr = w_head[W-1 -: 32];
    assign w_head_pc    = w_head[PC_W-1:0];
    assign w_nxt_instr  = w_head_nxt[W-1 -: 32];

    assign w_have1      = (w_count != '0);
    assign w_have2      = (w_count >= CW'(2));
    assign w_head_imm   = is_imm(w_head_instr);
    // An IMM at the head is only presentable together with its follower
    assign w_norm_valid = w_have1 && (!w_head_imm || w_have2);

    assign in_ready = reset_n && (w_count < CW'(DEPTH));
    assign w_push   = in_valid && in_ready && !flush;

`ifdef OPENFIRE_INT_INJECT_EN
    logic r_ds_pend;

    // Injection waits for a whole presentable unit, so it can never land
    // between an IMM prefix and its follower, nor ahead of a delay slot
    assign w_inject = int_req && !r_ds_pend && w_norm_valid;

    // Track whether the next consumed word is a delay slot
    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            r_ds_pend <= 1'b0;
        end else if (w_fire) begin
            r_ds_pend <= (w_src == SRC_INJECT) ? 1'b0 : delay_bit(out_instr);
        end
    end

    assign int_ack = w_fire && (w_src == SRC_INJECT);
`else
    assign w_inject = 1'b0;
`endif

    // Choose what DECODE sees this cycle
    always_comb begin
        w_src = SRC_NONE;
        if (w_inject) begin
            w_src = SRC_INJECT;
        end else if (w_norm_valid) begin
            w_src = w_head_imm ? SRC_FUSED : SRC_SINGLE;
        end
    end

    // Output mux; data outputs are zero whenever nothing is presented
    always_comb begin
        out_valid = 1'b0;
        out_instr = '0;
        out_pc    = '0;
        out_imm   = '0;
        out_fused = 1'b0;
        case (w_src)
            SRC_SINGLE: begin
                out_valid = 1'b1;
                out_instr = w_head_instr;
                out_pc    = w_head_pc;
                out_imm   = sext16(w_head_instr[15:0]);
            end
            SRC_FUSED: begin
                out_valid = 1'b1;
                out_instr = w_nxt_instr;
                out_pc    = w_head_pc;
                out_imm   = {w_head_instr[15:0], w_nxt_instr[15:0]};
                out_fused = 1'b1;
            end
            SRC_INJECT: begin
                out_valid = 1'b1;
                out_instr = brali(RET_RD, INT_VECTOR[15:0]);
                out_pc    = w_head_pc;
                out_imm   = INT_VECTOR;
            end
            default: ;
        endcase
    end

    assign w_fire = out_valid && out_ready && !flush;
    assign w_pop1 = w_fire && (w_src == SRC_SINGLE);
    assign w_pop2 = w_fire && (w_src == SRC_FUSED);

    openfire_ibuf_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_ibuf (
        .i_clock     (clock),
        .i_reset_n   (reset_n),
        .i_clear     (flush),
        .i_push      (w_push),
        .i_push_data ({in_instr, in_pc}),
        .i_pop1      (w_pop1),
        .i_pop2      (w_pop2),
        .o_head      (w_head),
        .o_head_nxt  (w_head_nxt),
        .o_count     (w_count)
    );

endmodule

// File: doc/openfire_decode_prefetch.md
# openfire_decode_prefetch

Parametrised instruction prefetch/fuse stage between FETCH and DECODE of the OpenFire core. Buffers fetched instructions in a DEPTH-entry queue so FETCH keeps running while DECODE is stalled. Fuses an IMM prefix with its follower into one 32-bit-immediate instruction so DECODE never issues a bubble for IMM. Optionally injects the interrupt branch only at legal points (never after IMM, never before a pending delay slot).

## Interface
- PC_W, 32: width of PC fields (A_SPACE+2 in the core).
- DEPTH, 4: queue entries; power of two, >= 2.
- INT_VECTOR, 32'h10: interrupt vector address.
- INT_RET_REG, 14: link register for the injected branch.
- clock  in  1  sole clock, all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- flush  in  1  branch taken; discard all buffered/presented instructions.
- in_valid  in  1  FETCH word valid.
- in_ready  out  1  queue accepts a word this cycle.
- in_instr  in  32  fetched instruction.
- in_pc  in  PC_W  its address.
- out_valid  out  1  instruction presented to DECODE.
- out_ready  in  1  DECODE consumes (i.e. not stalled).
- out_instr  out  32  instruction (follower when fused).
- out_pc  out  PC_W  address (IMM address when fused).
- out_imm  out  32  final immediate: {imm_hi, instr[15:0]} if fused, else sign-extended instr[15:0].
- out_fused  out  1  out_imm came from an IMM prefix.
- int_req  in  1  interrupt pending (level).
- int_ack  out  1  one-cycle pulse: injected branch consumed.

## Operation
- Push when in_valid & in_ready & !flush; pop on out_valid & out_ready. Handshake completes only when both valid and ready are high.
- Opcodes: IMM = 6'b101100, BR = 6'b100110, BCC = 6'b100111, RTS = 6'b101101.
- Delay bit:
  - BR: instr[20].
  - BCC: instr[25].
  - RTS: always 1.
- Head not IMM: present head, pop 1.
- Head IMM and count >= 2: present entry head+1 with out_pc = IMM pc, out_fused = 1, pop 2 atomically.
- Head IMM and count == 1: out_valid = 0 (wait for follower).
- ds_pend flag:
  - Set on consuming an instruction whose delay bit is 1.
  - Cleared on consuming the next instruction.
- Injection is legal when int_req & !ds_pend & count >= 1. While legal, the presented instruction is brali rINT_RET_REG, INT_VECTOR:
  - out_instr = {6'b101110, INT_RET_REG[4:0], 5'b01100, INT_VECTOR[15:0]}.
  - out_imm = INT_VECTOR.
  - out_pc = head pc; out_fused = 0.
  - The queue is not popped.
  - int_ack pulses on the consuming handshake.
- Flush:
  - Count → 0, ds_pend → 0, pointers → 0.
  - A simultaneous push or pop is discarded.
  - Flush wins over all events.
- Reset values: in_ready 0 during reset (1 after), out_valid 0, int_ack 0, out_fused 0, out_instr/out_pc/out_imm 0. Count, pointers and ds_pend are 0.
- Data outputs are forced to 0 whenever out_valid = 0.

## Timing
- Queue write is registered; head read is combinational (show-ahead). Word pushed in cycle N is presentable in cycle N+1.
- Fused pair presentable the cycle after the follower's push.
- in_ready = (count < DEPTH), from the registered count. No full-bypass: full with a simultaneous pop still gives in_ready = 0.
- Empty: out_valid = 0 even if in_valid is high (no input bypass).
- Pointers wrap modulo DEPTH.
- Count arithmetic is $clog2(DEPTH)+1 bits, with net change +1/0/-1/-2 per cycle.
- out_ready low holds all out_* stable. ds_pend updates only on handshakes.
- int_req deasserted before consumption withdraws the injected branch with no ack.

## Configuration
- OPENFIRE_INT_INJECT_EN defined: int_req/int_ack ports and injection logic are present.
- Undefined: ports are absent, ds_pend logic is removed, and behaviour is pure buffer plus fusion.

## Structure
- Opcode constants, delay-bit field positions and the brali template go in openfire_define.v, shared with DECODE.
- One sub-module, openfire_ibuf_fifo:
  - DEPTH x (32+PC_W) storage.
  - Provides peek of head and head+1, pop-1/pop-2, clear.
  - Owns the registered count.

## Test plan
- Reset, then push 0x30600005 at pc 0x100 with out_ready=1 → out_valid the next cycle, out_imm=0x00000005, out_fused=0.
- Push IMM 0xB0001234 @0x200, then ADDI 0x20605678 @0x204 → single output: pc 0x200, instr 0x20605678, imm 0x12345678, fused=1, count returns to 0.
- out_ready=0, push DEPTH=4 words → in_ready=0 after the 4th. Assert out_ready for 1 cycle → one pop, in_ready=1 the next cycle, order preserved.
- Flush while full and pushing 0xDEADBEEF → next cycle count=0, out_valid=0, 0xDEADBEEF never appears.
- OPENFIRE_INT_INJECT_EN: consume BRI with D=1 (0xB810_0008), assert int_req → delay-slot word is presented first; then brali r14,0x10 (0xB9CC0010) with out_pc = next head pc; int_ack pulses once.
- IMM at head with int_req high, follower arriving 3 cycles later → no injection or output until the follower arrives; the fused pair is not split.
